wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max wait cycles for wbm_ack_i in a bus cycle; 0 disables timeout.
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr  input  32  byte address.
REQ-008 SHALL have port cmd_dat  input  32  write data.
REQ-009 SHALL have port cmd_sel  input  4  byte lane selects.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-012 SHALL have port rsp_dat  output  32  read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err  output  1  1 = timeout.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic initiator controls.
REQ-015 SHALL have ports wbm_adr_o  output  32,  wbm_dat_o  output  32,  wbm_sel_o  output  4.
REQ-016 SHALL have ports wbm_ack_i  input  1,  wbm_dat_i  input  32  responder handshake/data.

Function
REQ-017 SHALL implement FSM with states IDLE, BUS, RESP; reset state IDLE.
REQ-018 In IDLE: cmd_ready = 1; all other states: cmd_ready = 0.
REQ-019 On accept in IDLE: register we/adr/dat/sel to wbm_* outputs, assert wbm_cyc_o and wbm_stb_o from the next cycle, clear timeout counter, go BUS.
REQ-020 In BUS: wbm_cyc_o = wbm_stb_o = 1; wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o stable for the whole cycle.
REQ-021 In BUS with wbm_ack_i = 1 at an edge: deassert cyc/stb next cycle; rsp_dat = wbm_dat_i if read else 0; rsp_err = 0; go RESP.
REQ-022 In BUS without ack: increment counter; when TIMEOUT != 0 and the count reaches TIMEOUT, deassert cyc/stb, rsp_dat = 0, rsp_err = 1, go RESP.
REQ-023 Ack and timeout on the same edge: ack wins (rsp_err = 0).
REQ-024 Timeout counter width: $clog2(TIMEOUT+1), minimum 1 bit; counter saturates, never wraps.
REQ-025 In RESP: rsp_valid = 1, rsp_dat/rsp_err held; on rsp_ready go IDLE; cmd_ready rises the cycle after the handshake (no same-cycle accept).
REQ-026 wbm_ack_i outside BUS SHALL be ignored.
REQ-027 Minimum command-to-response latency: ack in first BUS cycle -> rsp_valid asserted 2 cycles after command accept.
REQ-028 wbm_dat_o SHALL be driven with cmd_dat for reads as well (don't-care to responder).

Reset
REQ-029 On wb_rst_i: state IDLE; wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err = 0; wbm_adr_o, wbm_dat_o, rsp_dat, counter = 0; wbm_sel_o = 0.
REQ-030 Reset asserted mid-BUS SHALL drop cyc/stb immediately (asynchronously); pending command discarded, no response.

Structure
REQ-031 Shared package wb_cmd_pkg SHALL hold the FSM state encoding and the Wishbone width constants (ADR_W = 32, DAT_W = 32, SEL_W = 4).
REQ-032 Single module, no sub-modules; timeout counter inline.

Verification
REQ-033 Write adr 0x3000_0000, dat 0x0000_00FF, sel 0xF, responder acks 1st cycle -> one cyc/stb pulse with we = 1, rsp_valid 2 cycles after accept, rsp_err = 0, rsp_dat = 0.
REQ-034 Read adr 0x3000_0004, responder acks after 3 wait states with 0xDEAD_BEEF -> cyc/stb high 4 cycles, rsp_dat = 0xDEAD_BEEF, rsp_err = 0.
REQ-035 TIMEOUT = 4, responder never acks -> cyc/stb drop after 4 BUS cycles, rsp_err = 1, rsp_dat = 0.
REQ-036 TIMEOUT = 4, ack on the 4th BUS cycle -> rsp_err = 0, data captured.
REQ-037 rsp_ready held low 10 cycles, cmd_valid high throughout -> rsp held stable, cmd_ready = 0 until the cycle after the response handshake.
REQ-038 wb_rst_i pulsed during BUS wait -> cyc/stb low the same cycle, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/wb_cmd_pkg.sv
// rtl/wb_cmd_pkg.sv - Shared Wishbone widths and command-master FSM encoding.
package wb_cmd_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Command/response to Wishbone classic initiator bridge.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    input  logic             wbm_ack_i,
    input  logic [DAT_W-1:0] wbm_dat_i
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DAT_W-1:0] rsp_dat_q;
    logic             rsp_err_q;

    // Saturating increment: with TIMEOUT = 0 the counter parks at all-ones.
    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack is tested first so it wins over a timeout on the same edge.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat_q <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err_q <= 1'b0;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if ((TIMEOUT != 0) && (cnt_d == TO_VAL)) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            rsp_dat_q <= '0;
                            rsp_err_q <= 1'b1;
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - Directed self-checking bench for wb_cmd_master.
module tb_wb_cmd_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_cmd_master #(.TIMEOUT(4)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Issues one command and plays the responder: ack after ack_after wait states (-1 = never).
    // lat is the cycle index (accept cycle = 0) where rsp_valid is first seen, -1 if never.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_after, input logic [31:0] rdata,
                           output int cyc_cnt, output int lat, output logic stable_ok);
        cyc_cnt   = 0;
        lat       = -1;
        stable_ok = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        wbm_ack_i = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k < 40; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (wbm_cyc_o) begin
                cyc_cnt++;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
                    wbm_dat_o !== dat || wbm_sel_o !== sel)
                    stable_ok = 1'b0;
            end
            wbm_ack_i = (ack_after >= 0) && wbm_cyc_o && (cyc_cnt - 1 == ack_after);
            wbm_dat_i = wbm_ack_i ? rdata : 32'h5555_5555;
            tick();
        end
        wbm_ack_i = 1'b0;
    endtask

    task automatic rsp_accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic check_txn(input string name, input int cyc_cnt, input int lat, input logic stable_ok,
                             input int exp_cyc, input int exp_lat, input logic [31:0] exp_dat,
                             input logic exp_err);
        checks++;
        if (cyc_cnt !== exp_cyc) begin
            errors++;
            $display("FAIL %s_cyc_cycles got %0d want %0d", name, cyc_cnt, exp_cyc);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_bus_stable got %b want 1", name, stable_ok);
        end
        checks++;
        if (rsp_dat !== exp_dat || rsp_err !== exp_err) begin
            errors++;
            $display("FAIL %s_rsp got dat=%h err=%b want dat=%h err=%b", name, rsp_dat, rsp_err,
                     exp_dat, exp_err);
        end
        checks++;
        if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp_ctl got ready=%b cyc=%b stb=%b want 0 0 0", name, cmd_ready,
                     wbm_cyc_o, wbm_stb_o);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got valid=%b ready=%b cyc=%b want 0 1 0", name, rsp_valid,
                     cmd_ready, wbm_cyc_o);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err});
        end
        checks++;
        if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || rsp_dat !== 32'h0 || wbm_sel_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_data got adr=%h dat=%h rsp=%h sel=%h want 0", wbm_adr_o, wbm_dat_o,
                     rsp_dat, wbm_sel_o);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
        wb_rst_i = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int c, l;
        logic s;
        run_cmd(1'b1, 32'h3000_0000, 32'h0000_00FF, 4'hF, 0, 32'hFFFF_FFFF, c, l, s);
        check_txn("write", c, l, s, 1, 2, 32'h0, 1'b0);
        rsp_accept();
        check_idle("write");
    endtask

    task automatic test_read_wait();
        int c, l;
        logic s;
        run_cmd(1'b0, 32'h3000_0004, 32'h1111_2222, 4'hF, 3, 32'hDEAD_BEEF, c, l, s);
        check_txn("read_wait", c, l, s, 4, 5, 32'hDEAD_BEEF, 1'b0);
        rsp_accept();
        check_idle("read_wait");
    endtask

    task automatic test_timeout();
        int c, l;
        logic s;
        run_cmd(1'b0, 32'h4000_0000, 32'h0000_0000, 4'h3, -1, 32'h0, c, l, s);
        check_txn("timeout", c, l, s, 4, 5, 32'h0, 1'b1);
        rsp_accept();
        check_idle("timeout");
    endtask

    task automatic test_ack_at_limit();
        int c, l;
        logic s;
        run_cmd(1'b0, 32'h4000_0008, 32'h0BAD_F00D, 4'hC, 3, 32'h1234_5678, c, l, s);
        check_txn("ack_at_limit", c, l, s, 4, 5, 32'h1234_5678, 1'b0);
        rsp_accept();
        check_idle("ack_at_limit");
    endtask

    task automatic test_ack_ignored();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFE_0001;
        tick();
        tick();
        wbm_ack_i = 1'b0;
        check_idle("stray_ack");
    endtask

    task automatic test_backpressure();
        int c, l;
        logic s;
        run_cmd(1'b0, 32'h2000_0010, 32'h0, 4'hF, 0, 32'hA5A5_0001, c, l, s);
        check_txn("bp_read", c, l, s, 1, 2, 32'hA5A5_0001, 1'b0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h5000_0000;
        cmd_dat   = 32'h0000_A5A5;
        cmd_sel   = 4'h3;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hBAD0_0000;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A5_0001 || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b rdy=%b cyc=%b want 1 a5a50001 0 0 0",
                         i, rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc_o);
            end
            tick();
        end
        rsp_ready = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake_ready got %b want 0", cmd_ready);
        end
        tick();
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        check_idle("bp_after");
        run_cmd(1'b1, 32'h5000_0000, 32'h0000_A5A5, 4'h3, 1, 32'h7777_7777, c, l, s);
        check_txn("bp_next", c, l, s, 2, 3, 32'h0, 1'b0);
        rsp_accept();
        check_idle("bp_next");
    endtask

    task automatic test_reset_mid_bus();
        int c, l;
        logic s;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h6000_0000;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_bus got cyc=%b stb=%b want 1 1", wbm_cyc_o, wbm_stb_o);
        end
        #2 wb_rst_i = 1'b1;
        #1;
        checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got cyc=%b stb=%b valid=%b want 0 0 0", wbm_cyc_o, wbm_stb_o,
                     rsp_valid);
        end
        #3 wb_rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("midrst_quiet");
        end
        run_cmd(1'b1, 32'h6000_0100, 32'h1357_9BDF, 4'h5, 2, 32'h0, c, l, s);
        check_txn("midrst_next", c, l, s, 3, 4, 32'h0, 1'b0);
        rsp_accept();
        check_idle("midrst_next");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_ack_at_limit();
        test_ack_ignored();
        test_backpressure();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
